// File: rtl/async_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : async_fifo_pkg                                               |
// | Description : Shared types and constants for the async FIFO read side.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package async_fifo_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } rd_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_OCC_W = $clog2(SKID_DEPTH + 1);

    // RAM read latencies the read stream (and the FIFO top) know how to handle
    localparam int RD_LAT_MIN = 0;
    localparam int RD_LAT_MAX = 1;

endpackage
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rd_skid_buf                                                  |
// | Description : Small in-order word buffer with push/pop, occupancy and head.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rd_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [SKID_OCC_W-1:0] occ,
    output logic [DATA_W-1:0]     head
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam logic [SKID_OCC_W-1:0] OCC_FULL = SKID_OCC_W'(SKID_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(SKID_DEPTH - 1);

    logic [DATA_W-1:0] slots [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop & (occ != '0);
    // A push into a full buffer is only accepted when the head leaves the same cycle
    assign do_push = push & ((occ != OCC_FULL) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                slots[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = slots[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_rd_stream                                               |
// | Description : Read-domain consumer: pops the async FIFO under credit       |
// |               control and streams words out over valid/ready.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              enable,
    input  logic              rempty,
    output logic              rinc,
    input  logic [DATA_W-1:0] rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic              busy
);

    localparam logic [SKID_OCC_W:0] CREDITS = (SKID_OCC_W + 1)'(SKID_DEPTH);

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [SKID_OCC_W-1:0] occ;
    logic [SKID_OCC_W:0]   used;
    logic [SKID_OCC_W:0]   avail_used;
    logic                  inflight;
    logic                  xfer;
    logic                  pop;
    logic                  skid_push;

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("fifo_rd_stream: RD_LAT must be 0 or 1");
        end
    endgenerate

    assign xfer       = m_valid & m_ready;
    assign used       = {1'b0, occ} + {{SKID_OCC_W{1'b0}}, inflight};
    // A transfer this cycle frees its slot in time for a new pop
    assign avail_used = used - {{SKID_OCC_W{1'b0}}, xfer};

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_INIT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (!enable) begin
                    state_nxt = ST_HALT;
                end
                pop = enable & ~rempty & (avail_used < CREDITS);
            end
            ST_HALT: begin
                if (enable) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign rinc = pop;

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign inflight  = 1'b0;
            assign skid_push = pop;
        end else begin : g_lat1
            logic inflight_q;
            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) begin
                    inflight_q <= 1'b0;
                end else begin
                    inflight_q <= pop;
                end
            end
            assign inflight  = inflight_q;
            assign skid_push = inflight_q;
        end
    endgenerate

    rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .push      (skid_push),
        .push_data (rdata),
        .pop       (xfer),
        .occ       (occ),
        .head      (m_data)
    );

    assign m_valid = (occ != '0);
    assign busy    = m_valid | inflight;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_cnt <= '0;
        end else if (xfer) begin
            rd_cnt <= rd_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
